// File: rtl/emc_extbus_ctrl_pkg.sv
// emc_extbus_ctrl_pkg: shared state/grant encodings and helpers for the external bus controller
package emc_extbus_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LATCH, S_STROBE, S_DONE} state_t;
  typedef enum logic {GNT_FETCH = 1'b0, GNT_DATA = 1'b1} gnt_t;
  localparam int CNT_W = 3;
  function automatic logic [1:0] gnt_mask(gnt_t g);
    return (g == GNT_DATA) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/emc_extbus_ctrl_arb.sv
// emc_extbus_ctrl_arb: 2-way round-robin arbiter between code fetch (bit 0) and MOVX data (bit 1)
module emc_extbus_ctrl_arb
  import emc_extbus_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] excl,
  input  logic       take,
  output logic       valid,
  output gnt_t       gnt
);
  logic [1:0] live;
  gnt_t       last;
  // on a tie the requester that did not win last time gets the bus
  always_comb begin
    live  = req & ~excl;
    valid = |live;
    gnt   = (&live) ? ((last == GNT_FETCH) ? GNT_DATA : GNT_FETCH) : (live[1] ? GNT_DATA : GNT_FETCH);
  end
  // remember the winner only when the controller actually consumes the grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= GNT_FETCH;
    else if (take && valid) last <= gnt;
endmodule

// File: rtl/emc_extbus_ctrl.sv
// emc_extbus_ctrl: arbitrates fetch/MOVX and sequences one 8051-style multiplexed P0/P2 access per grant
module emc_extbus_ctrl
  import emc_extbus_ctrl_pkg::*;
#(
  parameter int STROBE_CYC = 2
) (
  input  logic        ebc_clock_i,
  input  logic        ebc_reset_i,
  input  logic        ebc_fetch_req_i,
  input  logic [15:0] ebc_fetch_addr_i,
  output logic        ebc_fetch_ack_o,
  output logic [7:0]  ebc_fetch_data_o,
  input  logic        ebc_data_req_i,
  input  logic        ebc_data_we_i,
  input  logic        ebc_data_short_i,
  input  logic [15:0] ebc_data_addr_i,
  input  logic [7:0]  ebc_data_wdata_i,
  output logic        ebc_data_ack_o,
  output logic [7:0]  ebc_data_rdata_o,
  input  logic [7:0]  ebc_p0_y_i,
  output logic [7:0]  ebc_p0_a_o,
  output logic [7:0]  ebc_p0_en_o,
  output logic [7:0]  ebc_p2_a_o,
  output logic        ebc_p0_sel_o,
  output logic        ebc_p2_sel_o,
  output logic        ebc_ale_o,
  output logic        ebc_psen_b_o,
  output logic        ebc_rd_b_o,
  output logic        ebc_wr_b_o,
  output logic        ebc_busy_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STROBE_CYC - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  gnt_t             gnt_q, gnt;
  logic             arb_ok, arb_phase, take;
  logic [1:0]       excl;
  logic [15:0]      addr_q;
  logic             we_q, short_q;
  logic [7:0]       wdata_q;
  logic             is_data, strobe, late, wr;

  // arbitration happens in IDLE and DONE; in DONE the requester being acked sits out
  always_comb begin
    arb_phase = (state == S_IDLE) || (state == S_DONE);
    excl      = (state == S_DONE) ? gnt_mask(gnt_q) : 2'b00;
    take      = arb_phase && arb_ok;
  end

  emc_extbus_ctrl_arb u_arb (
    .clk   (ebc_clock_i),
    .rst_n (ebc_reset_i),
    .req   ({ebc_data_req_i, ebc_fetch_req_i}),
    .excl  (excl),
    .take  (arb_phase),
    .valid (arb_ok),
    .gnt   (gnt)
  );

  // next-state logic: ADDR -> LATCH -> STROBE x STROBE_CYC -> DONE
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = arb_ok ? S_ADDR : S_IDLE;
      S_ADDR:   state_n = S_LATCH;
      S_LATCH:  state_n = S_STROBE;
      S_STROBE: state_n = (cnt == LAST) ? S_DONE : S_STROBE;
      S_DONE:   state_n = arb_ok ? S_ADDR : S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // state register and strobe-width counter
  always_ff @(posedge ebc_clock_i or negedge ebc_reset_i)
    if (!ebc_reset_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == S_STROBE) ? cnt + CNT_W'(1) : '0;
    end

  // capture the winner's request so its inputs may change once granted
  always_ff @(posedge ebc_clock_i or negedge ebc_reset_i)
    if (!ebc_reset_i) begin
      gnt_q   <= GNT_FETCH;
      addr_q  <= '0;
      we_q    <= 1'b0;
      short_q <= 1'b0;
      wdata_q <= '0;
    end else if (take) begin
      gnt_q   <= gnt;
      addr_q  <= (gnt == GNT_DATA) ? ebc_data_addr_i : ebc_fetch_addr_i;
      we_q    <= (gnt == GNT_DATA) && ebc_data_we_i;
      short_q <= (gnt == GNT_DATA) && ebc_data_short_i;
      wdata_q <= ebc_data_wdata_i;
    end

  // sample P0 on the edge that ends the last strobe cycle; each byte holds until its next read
  always_ff @(posedge ebc_clock_i or negedge ebc_reset_i)
    if (!ebc_reset_i) begin
      ebc_fetch_data_o <= '0;
      ebc_data_rdata_o <= '0;
    end else if (state == S_STROBE && cnt == LAST) begin
      if (gnt_q == GNT_FETCH) ebc_fetch_data_o <= ebc_p0_y_i;
      else if (!we_q) ebc_data_rdata_o <= ebc_p0_y_i;
    end

  // pad and strobe outputs decoded from state so reset releases the bus immediately
  always_comb begin
    is_data         = gnt_q == GNT_DATA;
    strobe          = state == S_STROBE;
    late            = strobe || (state == S_DONE);
    wr              = is_data && we_q;
    ebc_busy_o      = state != S_IDLE;
    ebc_ale_o       = state == S_ADDR;
    ebc_p0_sel_o    = ebc_busy_o;
    ebc_p2_sel_o    = ebc_busy_o && !(is_data && short_q);
    ebc_p0_a_o      = !ebc_busy_o ? 8'h00 : (late && wr) ? wdata_q : addr_q[7:0];
    ebc_p0_en_o     = (ebc_busy_o && !(late && !wr)) ? 8'hFF : 8'h00;
    ebc_p2_a_o      = ebc_p2_sel_o ? addr_q[15:8] : 8'h00;
    ebc_psen_b_o    = !(strobe && !is_data);
    ebc_rd_b_o      = !(strobe && is_data && !we_q);
    ebc_wr_b_o      = !(strobe && wr);
    ebc_fetch_ack_o = (state == S_DONE) && !is_data;
    ebc_data_ack_o  = (state == S_DONE) && is_data;
  end
endmodule

// File: tb/tb_emc_extbus_ctrl.sv
// tb_emc_extbus_ctrl: directed vectors, corner sequences and a randomized timeline-model check
module tb_emc_extbus_ctrl;
  localparam int NC = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_short = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0;
  logic [7:0] d_wdata = '0, p0_y = '0;
  logic f_ack, d_ack, p0_sel, p2_sel, ale, psen_b, rd_b, wr_b, busy;
  logic [7:0] f_data, d_rdata, p0_a, p0_en, p2_a;
  logic x_req [2];
  logic x_fack [2], x_dack [2], x_p0s [2], x_p2s [2], x_ale [2], x_psen [2], x_rd [2], x_wr [2], x_busy [2];
  logic [7:0] x_fd [2], x_rdd [2], x_p0a [2], x_p0en [2], x_p2a [2];
  int pass_n = 0, total_n = 0;

  always #5 clk = ~clk;

  emc_extbus_ctrl #(.STROBE_CYC(NC)) dut (
    .ebc_clock_i(clk), .ebc_reset_i(rst_n),
    .ebc_fetch_req_i(f_req), .ebc_fetch_addr_i(f_addr), .ebc_fetch_ack_o(f_ack), .ebc_fetch_data_o(f_data),
    .ebc_data_req_i(d_req), .ebc_data_we_i(d_we), .ebc_data_short_i(d_short), .ebc_data_addr_i(d_addr),
    .ebc_data_wdata_i(d_wdata), .ebc_data_ack_o(d_ack), .ebc_data_rdata_o(d_rdata),
    .ebc_p0_y_i(p0_y), .ebc_p0_a_o(p0_a), .ebc_p0_en_o(p0_en), .ebc_p2_a_o(p2_a),
    .ebc_p0_sel_o(p0_sel), .ebc_p2_sel_o(p2_sel), .ebc_ale_o(ale), .ebc_psen_b_o(psen_b),
    .ebc_rd_b_o(rd_b), .ebc_wr_b_o(wr_b), .ebc_busy_o(busy)
  );

  for (genvar g = 0; g < 2; g++) begin : g_alt
    emc_extbus_ctrl #(.STROBE_CYC(g ? 7 : 1)) u (
      .ebc_clock_i(clk), .ebc_reset_i(rst_n),
      .ebc_fetch_req_i(x_req[g]), .ebc_fetch_addr_i(16'h0F0F), .ebc_fetch_ack_o(x_fack[g]), .ebc_fetch_data_o(x_fd[g]),
      .ebc_data_req_i(1'b0), .ebc_data_we_i(1'b0), .ebc_data_short_i(1'b0), .ebc_data_addr_i(16'h0000),
      .ebc_data_wdata_i(8'h00), .ebc_data_ack_o(x_dack[g]), .ebc_data_rdata_o(x_rdd[g]),
      .ebc_p0_y_i(p0_y), .ebc_p0_a_o(x_p0a[g]), .ebc_p0_en_o(x_p0en[g]), .ebc_p2_a_o(x_p2a[g]),
      .ebc_p0_sel_o(x_p0s[g]), .ebc_p2_sel_o(x_p2s[g]), .ebc_ale_o(x_ale[g]), .ebc_psen_b_o(x_psen[g]),
      .ebc_rd_b_o(x_rd[g]), .ebc_wr_b_o(x_wr[g]), .ebc_busy_o(x_busy[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic fetch, we, sh;
    logic [15:0] addr;
    logic [7:0] wd, y, e_p0a, e_p2a;
    logic e_p2s;
    logic [7:0] e_dat;
    int e_lat;
  } vec_t;
  vec_t vt [6];

  initial begin
    vec_t c;
    int lat, n_ale, sw, so, viol, p2s, drv_bad, nlow, na, idle_n, rem, k;
    int tk [3];
    logic kd [3];
    int xl [2], xw [2];
    logic mine, kind_ok, own, m_last, e_we, e_sh, bsy, dn, strb, p2x;
    logic [7:0] a0, a2, dat, e_wd, e_fd, e_rd, en_x;
    logic [15:0] e_addr;
    logic [1:0] cand, ex;
    x_req[0] = 1'b0;
    x_req[1] = 1'b0;
    vt[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 8'h34, 8'h12, 1'b1, 8'hA5, 5};
    vt[1] = '{1'b0, 1'b1, 1'b0, 16'h80F0, 8'h5A, 8'h00, 8'hF0, 8'h80, 1'b1, 8'h5A, 5};
    vt[2] = '{1'b0, 1'b0, 1'b1, 16'hEE3C, 8'h00, 8'h77, 8'h3C, 8'h00, 1'b0, 8'h77, 5};
    vt[3] = '{1'b0, 1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h99, 8'hEF, 8'hBE, 1'b1, 8'h99, 5};
    vt[4] = '{1'b0, 1'b1, 1'b1, 16'h0011, 8'hC3, 8'h00, 8'h11, 8'h00, 1'b0, 8'hC3, 5};
    vt[5] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h6B, 8'hFF, 8'hFF, 1'b1, 8'h6B, 5};
    #3;
    chk("reset ctl", {busy, ale, psen_b, rd_b, wr_b, p0_sel, p2_sel, f_ack, d_ack}, 9'b0_0111_0000);
    chk("reset pads", {p0_a, p0_en, p2_a, f_data, d_rdata}, 40'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // directed single accesses from IDLE
    for (int v = 0; v < 6; v++) begin
      c = vt[v];
      p0_y = c.y;
      if (c.fetch) begin f_addr = c.addr; f_req = 1'b1; end
      else begin d_addr = c.addr; d_we = c.we; d_short = c.sh; d_wdata = c.wd; d_req = 1'b1; end
      lat = -1; n_ale = 0; sw = 0; so = 0; viol = 0; p2s = 0; drv_bad = 0;
      a0 = '0; a2 = '0; dat = '0; kind_ok = 1'b0;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
        tick();
        if (ale) begin n_ale++; a0 = p0_a; a2 = p2_a; if (p0_en != 8'hFF) drv_bad++; end
        if (p2_sel) p2s = 1;
        mine = c.fetch ? !psen_b : c.we ? !wr_b : !rd_b;
        nlow = int'(!psen_b) + int'(!rd_b) + int'(!wr_b);
        if (mine) begin
          sw++;
          if (p0_en != ((c.we && !c.fetch) ? 8'hFF : 8'h00)) drv_bad++;
          if (c.we && !c.fetch && p0_a != c.wd) drv_bad++;
        end
        so += nlow - int'(mine);
        if (ale && nlow > 0) viol++;
        if (f_ack || d_ack) begin
          lat = i;
          kind_ok = c.fetch ? (f_ack && !d_ack) : (d_ack && !f_ack);
          dat = c.fetch ? f_data : c.we ? p0_a : d_rdata;
          if (!c.fetch && c.we && p0_en != 8'hFF) drv_bad++;
          if (!c.fetch && !c.we && p0_en != 8'h00) drv_bad++;
          f_req = 1'b0;
          d_req = 1'b0;
        end
      end
      f_req = 1'b0;
      d_req = 1'b0;
      tick();
      chk($sformatf("v%0d latency", v), lat, c.e_lat);
      chk($sformatf("v%0d ack kind", v), kind_ok, 1'b1);
      chk($sformatf("v%0d data", v), dat, c.e_dat);
      chk($sformatf("v%0d ale cycles", v), n_ale, 1);
      chk($sformatf("v%0d p0 addr", v), a0, c.e_p0a);
      if (c.e_p2s) chk($sformatf("v%0d p2 addr", v), a2, c.e_p2a);
      chk($sformatf("v%0d p2 sel", v), p2s, c.e_p2s);
      chk($sformatf("v%0d strobe width", v), sw, NC);
      chk($sformatf("v%0d other strobes", v), so + viol, 0);
      chk($sformatf("v%0d p0 drive", v), drv_bad, 0);
      chk($sformatf("v%0d back idle", v), busy, 1'b0);
    end
    chk("hold fetch data", f_data, 8'h6B);
    chk("hold read data", d_rdata, 8'h99);
    // request dropped right after grant still completes; inputs changed after grant are ignored
    f_addr = 16'h0ABC;
    f_req = 1'b1;
    tick();
    chk("early ale", ale, 1'b1);
    f_req = 1'b0;
    f_addr = 16'h5555;
    tick();
    chk("early latched addr", {p2_a, p0_a}, 16'h0ABC);
    lat = -1;
    for (int i = 3; i <= 12 && lat < 0; i++) begin
      tick();
      if (f_ack) lat = i;
    end
    chk("early drop ack latency", lat, NC + 3);
    tick();
    // reset in the middle of a read strobe
    d_addr = 16'h4321; d_we = 1'b0; d_short = 1'b0; d_req = 1'b1;
    for (int i = 0; i < 10 && rd_b; i++) tick();
    chk("rst reached strobe", rd_b, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst abort ctl", {rd_b, psen_b, wr_b, ale, busy, d_ack, p0_sel}, 7'b1110000);
    chk("rst abort p0_en", p0_en, 8'h00);
    d_req = 1'b0;
    tick();
    chk("rst no ack", {d_ack, f_ack, busy}, 3'b000);
    rst_n = 1'b1;
    tick();
    // both requesting continuously: data wins first after reset, then strict alternation
    f_addr = 16'h1111; d_addr = 16'h2222; p0_y = 8'h3E;
    f_req = 1'b1; d_req = 1'b1;
    na = 0; idle_n = 0;
    for (int i = 0; i < 3; i++) begin tk[i] = 0; kd[i] = 1'b0; end
    for (int i = 1; i <= 40 && na < 3; i++) begin
      tick();
      if (na > 0 && !busy) idle_n++;
      if (f_ack || d_ack) begin tk[na] = i; kd[na] = d_ack; na++; end
    end
    f_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    chk("rr ack count", na, 3);
    chk("rr order", {kd[0], kd[1], kd[2]}, 3'b101);
    chk("rr first latency", tk[0], NC + 3);
    chk("rr spacing 1", tk[1] - tk[0], NC + 3);
    chk("rr spacing 2", tk[2] - tk[1], NC + 3);
    chk("rr idle cycles", idle_n, 0);
    // alternate strobe widths
    for (int g = 0; g < 2; g++) begin xl[g] = -1; xw[g] = 0; x_req[g] = 1'b1; end
    for (int i = 1; i <= 15; i++) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        if (!x_psen[g]) xw[g]++;
        if (x_fack[g] && xl[g] < 0) begin xl[g] = i; x_req[g] = 1'b0; end
      end
    end
    chk("N1 latency", xl[0], 4);
    chk("N7 latency", xl[1], 10);
    chk("N1 strobe width", xw[0], 1);
    chk("N7 strobe width", xw[1], 7);
    // randomized traffic against a timeline model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rem = 0; own = 1'b0; m_last = 1'b0; e_we = 1'b0; e_sh = 1'b0; e_addr = '0; e_wd = '0; e_fd = '0; e_rd = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (rem <= 1) begin
        ex = (rem == 1) ? (own ? 2'b10 : 2'b01) : 2'b00;
        cand = {d_req, f_req} & ~ex;
        if (cand != 2'b00) begin
          own = (cand == 2'b11) ? ~m_last : cand[1];
          m_last = own;
          rem = NC + 3;
          e_addr = own ? d_addr : f_addr;
          e_we = own && d_we;
          e_sh = own && d_short;
          e_wd = d_wdata;
        end else rem = 0;
      end else begin
        if (rem == 2) begin
          if (!own) e_fd = p0_y;
          else if (!e_we) e_rd = p0_y;
        end
        rem--;
      end
      tick();
      k = NC + 3 - rem;
      bsy = rem > 0;
      strb = bsy && k >= 2 && k <= NC + 1;
      dn = bsy && k == NC + 2;
      p2x = bsy && !(own && e_sh);
      chk("rand ctl", {busy, ale, psen_b, rd_b, wr_b, p0_sel, p2_sel, f_ack, d_ack},
          {bsy, bsy && k == 0, !(strb && !own), !(strb && own && !e_we), !(strb && e_we), bsy, p2x, dn && !own, dn && own});
      en_x = (bsy && (k < 2 || e_we)) ? 8'hFF : 8'h00;
      chk("rand p0_en", p0_en, en_x);
      if (en_x != 8'h00) chk("rand p0_a", p0_a, (k >= 2 && e_we) ? e_wd : e_addr[7:0]);
      if (p2x) chk("rand p2_a", p2_a, e_addr[15:8]);
      chk("rand rdata", {f_data, d_rdata}, {e_fd, e_rd});
      if (dn) begin
        if (own) d_req = 1'b0;
        else f_req = 1'b0;
      end else if (bsy) begin
        if (own) begin d_addr = 16'($urandom); d_we = 1'($urandom); d_short = 1'($urandom); d_wdata = 8'($urandom); end
        else f_addr = 16'($urandom);
      end
      if (!f_req && $urandom_range(0, 2) == 0) begin f_addr = 16'($urandom); f_req = 1'b1; end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_addr = 16'($urandom); d_we = 1'($urandom); d_short = 1'($urandom); d_wdata = 8'($urandom); d_req = 1'b1;
      end
      p0_y = 8'($urandom);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
